// File: rtl/fifo_pop_ctrl_pkg.sv
// fifo_pop_ctrl_pkg
// Shared definitions for the FIFO consumer-side pop controller:
//   - controller state encoding (IDLE/STREAM/FLUSH/ERR)
//   - default word and counter widths
//   - skid buffer depth and the read-credit helper
package fifo_pop_ctrl_pkg;

  localparam int WORD_SIZE_DEF = 6;
  localparam int CNT_W_DEF     = 8;
  localparam int SKID_DEPTH    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // A new pop is allowed only if every word already owed to the skid buffer
  // (buffered plus in flight) still leaves a free slot for the new one.
  function automatic logic has_credit(input logic [1:0] occ, input logic inflight);
    return ({1'b0, occ} + {2'b00, inflight}) < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_pop_ctrl_if.sv
// fifo_pop_ctrl_if
// Bundles the FIFO read port and the downstream valid/ready stream seen by
// the pop controller.
//   fifo_data_out  FIFO read data (valid one cycle after fifo_rd)
//   fifo_empty     FIFO empty flag
//   almost_empty   FIFO occupancy at or below its empty threshold
//   fifo_error     FIFO overflow/underflow flag
//   fifo_rd        pop request to the FIFO
//   data_out       word presented downstream
//   valid_out      data_out holds a word
//   ready_in       downstream accepts a word this cycle
// Modports: master = pop controller, slave = FIFO + downstream side.
interface fifo_pop_ctrl_if import fifo_pop_ctrl_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF
);
  logic [WORD_SIZE-1:0] fifo_data_out;
  logic                 fifo_empty;
  logic                 almost_empty;
  logic                 fifo_error;
  logic                 fifo_rd;
  logic [WORD_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;

  modport master (
    input  fifo_data_out, fifo_empty, almost_empty, fifo_error, ready_in,
    output fifo_rd, data_out, valid_out
  );

  modport slave (
    output fifo_data_out, fifo_empty, almost_empty, fifo_error, ready_in,
    input  fifo_rd, data_out, valid_out
  );
endinterface

// File: rtl/fifo_pop_ctrl_skid_buf2.sv
// skid_buf2
// Two-entry in-order register queue. Entry 0 is always the head, so the
// output is a plain register with no path from i_pop.
//   clk, reset  clock, synchronous active-high reset
//   i_push      write i_din this cycle
//   i_din       data to write
//   i_pop       remove the head this cycle (ignored when empty)
//   o_dout      head entry
//   o_occ       number of stored entries (0..2)
module skid_buf2 import fifo_pop_ctrl_pkg::*; #(
  parameter int WIDTH = WORD_SIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] r_entry    [SKID_DEPTH];
  logic [WIDTH-1:0] w_shift_in [SKID_DEPTH];
  logic [1:0]       r_occ;
  logic [1:0]       w_wr_idx;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop & (r_occ != 2'd0);
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign w_push = i_push & (w_pop | (r_occ != 2'(SKID_DEPTH)));
  // On a simultaneous pop everything shifts down one slot, so the write lands
  // one position lower than the current occupancy.
  assign w_wr_idx = w_pop ? (r_occ - 2'd1) : r_occ;

  // Value each entry takes when the queue shifts toward the head.
  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_shift
      if (gi < SKID_DEPTH - 1) begin : g_mid
        assign w_shift_in[gi] = r_entry[gi+1];
      end else begin : g_last
        assign w_shift_in[gi] = r_entry[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      for (int i = 0; i < SKID_DEPTH; i++) begin
        if (w_push && (w_wr_idx == 2'(i))) begin
          r_entry[i] <= i_din;
        end else if (w_pop) begin
          r_entry[i] <= w_shift_in[i];
        end
      end
    end
  end

  assign o_dout = r_entry[0];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl
// Consumer-side controller for the FIFO memory block. Pops words with
// fifo_rd, lands them in a 2-entry skid buffer and hands them downstream
// over valid/ready without loss or duplication.
//   clk          single clock, posedge
//   reset        synchronous, active-high, priority over everything
//   bus          fifo_pop_ctrl_if.master (FIFO read side + downstream stream)
//   i_flush      level: drain the FIFO ignoring the almost_empty gate
//   o_pop_count  words delivered downstream since reset (wraps)
//   o_err_out    sticky error (FIFO error or pop while empty)
module fifo_pop_ctrl import fifo_pop_ctrl_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  fifo_pop_ctrl_if.master  bus,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_pop_count,
  output logic             o_err_out
);

  state_e               r_state;
  state_e               w_state_next;
  logic                 r_inflight;
  logic                 r_err;
  logic [CNT_W-1:0]     r_pop_count;
  logic [1:0]           w_occ;
  logic [WORD_SIZE-1:0] w_head;
  logic                 w_credit;
  logic                 w_fifo_rd;
  logic                 w_pop_bad;
  logic                 w_xfer;

  assign w_credit = has_credit(w_occ, r_inflight);
  assign w_xfer   = (w_occ != 2'd0) & bus.ready_in;

  always_comb begin
    w_state_next = r_state;
    w_fifo_rd    = 1'b0;
    w_pop_bad    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_flush && !bus.fifo_empty) begin
          w_state_next = ST_FLUSH;
        end else if (!bus.almost_empty && !bus.fifo_empty) begin
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // The state only updates on the next edge, so the threshold is also
        // applied here to stop at almost_empty instead of one word below it.
        w_fifo_rd = w_credit & !bus.fifo_empty & (!bus.almost_empty | i_flush);
        if (i_flush) begin
          w_state_next = ST_FLUSH;
        end else if (bus.almost_empty) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_fifo_rd = w_credit & !bus.fifo_empty;
        if (bus.fifo_empty && !r_inflight && !i_flush) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_fifo_rd = 1'b0;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // No pop may reach the FIFO while reset is held, whatever the state.
    if (reset) begin
      w_fifo_rd = 1'b0;
    end
    // Defensive: the gating above should make this unreachable.
    w_pop_bad = w_fifo_rd & bus.fifo_empty;
    if (bus.fifo_error || w_pop_bad) begin
      w_state_next = ST_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_inflight  <= 1'b0;
      r_err       <= 1'b0;
      r_pop_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_fifo_rd;
      if (bus.fifo_error || w_pop_bad) begin
        r_err <= 1'b1;
      end
      if (w_xfer) begin
        r_pop_count <= r_pop_count + CNT_W'(1);
      end
    end
  end

  // The word returned for last cycle's pop is always captured; the credit
  // rule guarantees a free slot for it even if ready_in dropped.
  skid_buf2 #(.WIDTH(WORD_SIZE)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_push (r_inflight),
    .i_din  (bus.fifo_data_out),
    .i_pop  (w_xfer),
    .o_dout (w_head),
    .o_occ  (w_occ)
  );

  assign bus.fifo_rd   = w_fifo_rd;
  assign bus.data_out  = w_head;
  assign bus.valid_out = (w_occ != 2'd0);
  assign o_pop_count   = r_pop_count;
  assign o_err_out     = r_err;

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl
// Directed bench for fifo_pop_ctrl. A behavioural FIFO (almost_empty when
// occupancy <= 1) feeds two controllers with identical inputs: one with an
// 8-bit pop counter and one with a 3-bit counter for the wrap case.
module tb_fifo_pop_ctrl;

  localparam int WS = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic ready = 1'b1;
  logic m_err = 1'b0;
  logic m_empty = 1'b1;
  logic m_ae = 1'b1;
  logic [WS-1:0] m_data = '0;

  logic [7:0] pop8;
  logic [2:0] pop3;
  logic       err8;
  logic       err3;

  logic [WS-1:0] fifo_q [$];
  logic [WS-1:0] pend_q [$];
  logic [WS-1:0] exp_q  [$];
  logic [WS-1:0] next_w = 6'd1;

  int n_chk = 0;
  int n_pass = 0;
  int rd_cnt = 0;
  int rd_empty_cnt = 0;
  int rd_rst_cnt = 0;
  int n_deliv = 0;
  int extra_cnt = 0;
  int base;
  int r0;

  always #5 clk = ~clk;

  fifo_pop_ctrl_if #(.WORD_SIZE(WS)) bus8 ();
  fifo_pop_ctrl_if #(.WORD_SIZE(WS)) bus3 ();

  assign bus8.fifo_data_out = m_data;
  assign bus8.fifo_empty    = m_empty;
  assign bus8.almost_empty  = m_ae;
  assign bus8.fifo_error    = m_err;
  assign bus8.ready_in      = ready;
  assign bus3.fifo_data_out = m_data;
  assign bus3.fifo_empty    = m_empty;
  assign bus3.almost_empty  = m_ae;
  assign bus3.fifo_error    = m_err;
  assign bus3.ready_in      = ready;

  fifo_pop_ctrl #(.WORD_SIZE(WS), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus8),
    .i_flush     (flush),
    .o_pop_count (pop8),
    .o_err_out   (err8)
  );

  fifo_pop_ctrl #(.WORD_SIZE(WS), .CNT_W(3)) dut_w3 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus3),
    .i_flush     (flush),
    .o_pop_count (pop3),
    .o_err_out   (err3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Behavioural FIFO: pops on fifo_rd, data valid the following cycle.
  always @(posedge clk) begin
    if (bus8.fifo_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (reset) rd_rst_cnt <= rd_rst_cnt + 1;
      if (fifo_q.size() == 0) rd_empty_cnt <= rd_empty_cnt + 1;
      else m_data <= fifo_q.pop_front();
    end
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    m_empty <= (fifo_q.size() == 0);
    m_ae    <= (fifo_q.size() <= 1);
  end

  // Downstream sink and in-order scoreboard.
  always @(posedge clk) begin
    if (!reset && bus8.valid_out && ready) begin
      $display("xfer %0d data=%0d", n_deliv, bus8.data_out);
      n_deliv <= n_deliv + 1;
      if (exp_q.size() == 0) extra_cnt <= extra_cnt + 1;
      else begin
        chk("word_order", {26'd0, bus8.data_out}, {26'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      pend_q.push_back(next_w);
      exp_q.push_back(next_w);
      next_w = next_w + 6'd1;
    end
  endtask

  task automatic wait_deliv(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_deliv < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (n_deliv >= target) ? 1 : 0, 1);
  endtask

  task automatic do_reset(input int npush, input logic rdy);
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    m_err = 1'b0;
    ready = rdy;
    fifo_q.delete();
    pend_q.delete();
    exp_q.delete();
    push_words(npush);
    repeat (5) @(negedge clk);
    chk("rst_fifo_rd", bus8.fifo_rd, 0);
    chk("rst_valid", bus8.valid_out, 0);
    chk("rst_data", bus8.data_out, 0);
    chk("rst_pop_count", pop8, 0);
    chk("rst_err", err8, 0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Threshold gate: one word (almost_empty) sits untouched, then 3 more.
    do_reset(1, 1'b1);
    base = n_deliv;
    r0 = rd_cnt;
    repeat (10) @(negedge clk);
    chk("gate_no_rd", rd_cnt - r0, 0);
    chk("gate_no_valid", bus8.valid_out, 0);
    push_words(3);
    wait_deliv("thr_deliv", base + 3, 40);
    r0 = rd_cnt;
    repeat (10) @(negedge clk);
    chk("thr_stop_no_rd", rd_cnt - r0, 0);
    chk("thr_pop_count", pop8, 3);
    chk("thr_fifo_left", fifo_q.size(), 1);

    // Backpressure: ready low stops after exactly two pops.
    do_reset(5, 1'b0);
    base = n_deliv;
    r0 = rd_cnt;
    repeat (12) @(negedge clk);
    chk("bp_pops", rd_cnt - r0, 2);
    chk("bp_rd_low", bus8.fifo_rd, 0);
    chk("bp_valid", bus8.valid_out, 1);
    chk("bp_head", {26'd0, bus8.data_out}, {26'd0, exp_q[0]});
    chk("bp_fifo_left", fifo_q.size(), 3);
    ready = 1'b1;
    wait_deliv("bp_deliv", base + 4, 30);
    repeat (8) @(negedge clk);
    chk("bp_pop_count", pop8, 4);
    chk("bp_fifo_end", fifo_q.size(), 1);

    // Flush: last word drained past the threshold, then back to IDLE.
    do_reset(1, 1'b1);
    base = n_deliv;
    r0 = rd_cnt;
    repeat (4) @(negedge clk);
    chk("fl_idle_no_rd", rd_cnt - r0, 0);
    flush = 1'b1;
    wait_deliv("fl_deliv", base + 1, 20);
    repeat (4) @(negedge clk);
    chk("fl_pop_count", pop8, 1);
    chk("fl_fifo_empty", fifo_q.size(), 0);
    chk("fl_no_rd_empty", rd_empty_cnt, 0);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    push_words(1);
    r0 = rd_cnt;
    repeat (8) @(negedge clk);
    chk("fl_back_idle", rd_cnt - r0, 0);

    // Error mid-stream with both skid slots full.
    do_reset(6, 1'b0);
    base = n_deliv;
    repeat (8) @(negedge clk);
    chk("er_valid", bus8.valid_out, 1);
    m_err = 1'b1;
    @(negedge clk);
    m_err = 1'b0;
    chk("er_err_set", err8, 1);
    chk("er_err_set_w3", err3, 1);
    ready = 1'b1;
    r0 = rd_cnt;
    wait_deliv("er_deliv", base + 2, 20);
    repeat (8) @(negedge clk);
    chk("er_no_rd", rd_cnt - r0, 0);
    chk("er_pop_count", pop8, 2);
    chk("er_sticky", err8, 1);
    chk("er_fifo_kept", fifo_q.size(), 4);

    // Counter wrap on the 3-bit instance, then reset mid-burst.
    do_reset(10, 1'b1);
    base = n_deliv;
    wait_deliv("wr_deliv", base + 9, 60);
    repeat (10) @(negedge clk);
    chk("wr_pop3", pop3, 1);
    chk("wr_pop8", pop8, 9);
    chk("wr_fifo_left", fifo_q.size(), 1);
    push_words(8);
    wait_deliv("mr_deliv", base + 11, 40);
    reset = 1'b1;
    fifo_q.delete();
    pend_q.delete();
    exp_q.delete();
    #1;
    chk("mr_rd_in_reset", bus8.fifo_rd, 0);
    @(negedge clk);
    chk("mr_fifo_rd", bus8.fifo_rd, 0);
    chk("mr_valid", bus8.valid_out, 0);
    chk("mr_data", bus8.data_out, 0);
    chk("mr_pop8", pop8, 0);
    chk("mr_pop3", pop3, 0);
    chk("mr_err", err8, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    chk("no_rd_while_empty", rd_empty_cnt, 0);
    chk("no_rd_in_reset", rd_rst_cnt, 0);
    chk("no_extra_words", extra_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
